// File: rtl/my_memory.sv
//------------------------------------------------------------------------------
// Module      : my_memory
// Description : Hack data memory (RAM, screen, keyboard) with a display-scan
//               port, a screen-write mirror stream and a post-reset clearer.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module my_memory #(
    parameter int CLEAR_ON_RESET = 1,
    parameter int CLEAR_WORDS    = 8192
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] inM,
    input  logic [15:0] outM,
    input  logic        writeM,
    input  logic [14:0] addressM,
    input  logic [15:0] kbd_code,
    input  logic        kbd_strobe,
    input  logic        kbd_release,
    input  logic [12:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        scr_we,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        clr_busy
);

    localparam logic [12:0] c_LAST = 13'(CLEAR_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [15:0] r_ram    [0:16383];
    logic [15:0] r_screen [0:8191];

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [15:0] r_kbd;
    logic [15:0] r_disp_data;
    logic        r_scr_we;
    logic [12:0] r_scr_addr;
    logic [15:0] r_scr_data;

    logic        w_busy;
    logic        w_clr_we;
    logic        w_cpu_scr_we;
    logic        w_ram_we;
    logic        w_scr_we;
    logic [12:0] w_scr_idx;
    logic [15:0] w_scr_wdata;

    assign w_busy       = (r_state == S_CLEAR);
    assign w_clr_we     = w_busy && !reset;
    // The clearer owns the screen while busy, so CPU and clear writes never collide.
    assign w_cpu_scr_we = writeM && (addressM[14:13] == 2'b10) && !w_busy && !reset;
    assign w_ram_we     = writeM && !addressM[14];
    assign w_scr_we     = w_clr_we || w_cpu_scr_we;
    assign w_scr_idx    = w_clr_we ? r_cnt : addressM[12:0];
    assign w_scr_wdata  = w_clr_we ? 16'h0000 : outM;

    always_comb begin
        inM = 16'h0000;
        case (addressM[14:13])
            2'b00, 2'b01: inM = r_ram[addressM[13:0]];
            2'b10:        inM = r_screen[addressM[12:0]];
            default:      inM = (addressM[12:0] == 13'h0000) ? r_kbd : 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[addressM[13:0]] <= outM;
        end
    end

    always_ff @(posedge clk) begin
        if (w_scr_we) begin
            r_screen[w_scr_idx] <= w_scr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_cnt   <= 13'h0000;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 13'h0001;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd <= 16'h0000;
        end else if (kbd_strobe) begin
            r_kbd <= kbd_code;
        end else if (kbd_release) begin
            r_kbd <= 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_busy) begin
            r_disp_data <= 16'h0000;
        end else begin
            r_disp_data <= r_screen[disp_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scr_we   <= 1'b0;
            r_scr_addr <= 13'h0000;
            r_scr_data <= 16'h0000;
        end else begin
            r_scr_we <= w_scr_we;
            if (w_scr_we) begin
                r_scr_addr <= w_scr_idx;
                r_scr_data <= w_scr_wdata;
            end
        end
    end

    assign disp_data = r_disp_data;
    assign scr_we    = r_scr_we;
    assign scr_addr  = r_scr_addr;
    assign scr_data  = r_scr_data;
    assign clr_busy  = w_busy;

endmodule

`default_nettype wire
